// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port SRAM arbiter.
//   State encoding (2 bits so that unused encodings exist and fall back to IDLE),
//   port identifiers and read/write codes.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;

    localparam logic PORT_UART = 1'b0;
    localparam logic PORT_CPU  = 1'b1;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the UART host, the CPU, the arbiter and the SRAM.
//   uart_* / cpu_* : requester side (enable, readWrite, address, dataIn in; dataOut, done out)
//   sram_*         : single-port SRAM side
//   busy           : arbiter activity flag
// Modports: slave = arbiter view, master = requester/SRAM view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  uart_enable;
    logic                  uart_readWrite;
    logic [ADDR_WIDTH-1:0] uart_address;
    logic [DATA_WIDTH-1:0] uart_dataIn;
    logic [DATA_WIDTH-1:0] uart_dataOut;
    logic                  uart_done;

    logic                  cpu_enable;
    logic                  cpu_readWrite;
    logic [ADDR_WIDTH-1:0] cpu_address;
    logic [DATA_WIDTH-1:0] cpu_dataIn;
    logic [DATA_WIDTH-1:0] cpu_dataOut;
    logic                  cpu_done;

    logic                  sram_enable;
    logic                  sram_readWrite;
    logic [ADDR_WIDTH-1:0] sram_address;
    logic [DATA_WIDTH-1:0] sram_dataIn;
    logic [DATA_WIDTH-1:0] sram_dataOut;

    logic                  busy;

    modport slave (
        input  uart_enable, uart_readWrite, uart_address, uart_dataIn,
        output uart_dataOut, uart_done,
        input  cpu_enable, cpu_readWrite, cpu_address, cpu_dataIn,
        output cpu_dataOut, cpu_done,
        output sram_enable, sram_readWrite, sram_address, sram_dataIn,
        input  sram_dataOut,
        output busy
    );

    modport master (
        output uart_enable, uart_readWrite, uart_address, uart_dataIn,
        input  uart_dataOut, uart_done,
        output cpu_enable, cpu_readWrite, cpu_address, cpu_dataIn,
        input  cpu_dataOut, cpu_done,
        input  sram_enable, sram_readWrite, sram_address, sram_dataIn,
        output sram_dataOut,
        input  busy
    );

endinterface

// File: rtl/mem_arb_req_latch.sv
// Per-port request capture: detects a 0->1 enable transition and buffers the request.
//   i_enable/i_rw/i_addr/i_data : requester inputs
//   i_clear                     : granted access of this port completes this edge
//   o_pending/o_rw/o_addr/o_data: buffered request
module mem_arb_req_latch #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic                  i_rw,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_clear,
    output logic                  o_pending,
    output logic                  o_rw,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_en_d;
    logic                  r_pending;
    logic                  r_rw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_rise;
    logic                  w_load;

    // A new edge is accepted when the buffer is free or frees at this same edge.
    assign w_rise = i_enable & ~r_en_d;
    assign w_load = w_rise & (~r_pending | i_clear);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en_d    <= 1'b0;
            r_pending <= 1'b0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
        end else begin
            r_en_d <= i_enable;
            if (w_load) begin
                r_pending <= 1'b1;
                r_rw      <= i_rw;
                r_addr    <= i_addr;
                r_data    <= i_data;
            end else if (i_clear) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_rw      = r_rw;
    assign o_addr    = r_addr;
    assign o_data    = r_data;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the UART host and the CPU shared access to one single-port SRAM.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_arbiter_if.slave (uart_*, cpu_*, sram_*, busy)
// Optional MEM_ARB_STATS_EN adds stats_clear, uart_grant_count, cpu_grant_count, conflict_count.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 15,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_arbiter_if.slave         bus
`ifdef MEM_ARB_STATS_EN
    ,
    input  logic                 stats_clear,
    output logic [CNT_WIDTH-1:0] uart_grant_count,
    output logic [CNT_WIDTH-1:0] cpu_grant_count,
    output logic [CNT_WIDTH-1:0] conflict_count
`endif
);

    localparam int unsigned LAT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic                  r_last_grant;
    logic                  r_grant_port;
    logic                  r_sram_en;
    logic                  r_sram_rw;
    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic [DATA_WIDTH-1:0] r_sram_data;
    logic                  r_uart_done;
    logic                  r_cpu_done;
    logic [DATA_WIDTH-1:0] r_uart_data;
    logic [DATA_WIDTH-1:0] r_cpu_data;

    logic                  w_pend_u, w_rw_u, w_pend_c, w_rw_c;
    logic [ADDR_WIDTH-1:0] w_addr_u, w_addr_c;
    logic [DATA_WIDTH-1:0] w_data_u, w_data_c;
    logic                  w_grant, w_grant_port, w_tie, w_finish;
    logic                  w_clr_u, w_clr_c;

    mem_arb_req_latch #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_req_uart (
        .clk(clk), .rst(rst),
        .i_enable(bus.uart_enable), .i_rw(bus.uart_readWrite),
        .i_addr(bus.uart_address), .i_data(bus.uart_dataIn), .i_clear(w_clr_u),
        .o_pending(w_pend_u), .o_rw(w_rw_u), .o_addr(w_addr_u), .o_data(w_data_u)
    );

    mem_arb_req_latch #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_req_cpu (
        .clk(clk), .rst(rst),
        .i_enable(bus.cpu_enable), .i_rw(bus.cpu_readWrite),
        .i_addr(bus.cpu_address), .i_data(bus.cpu_dataIn), .i_clear(w_clr_c),
        .o_pending(w_pend_c), .o_rw(w_rw_c), .o_addr(w_addr_c), .o_data(w_data_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, grant decision and access completion
    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_grant_port = r_grant_port;
        w_tie        = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend_u && w_pend_c) begin
                    w_tie        = 1'b1;
                    w_grant      = 1'b1;
                    w_grant_port = ~r_last_grant;
                end else if (w_pend_u) begin
                    w_grant      = 1'b1;
                    w_grant_port = PORT_UART;
                end else if (w_pend_c) begin
                    w_grant      = 1'b1;
                    w_grant_port = PORT_CPU;
                end
                if (w_grant) w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (r_lat_cnt == LAT_W'(MEM_LATENCY)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_clr_u = w_finish & (r_grant_port == PORT_UART);
    assign w_clr_c = w_finish & (r_grant_port == PORT_CPU);

    // SRAM drive, latency counter, read-data capture and done pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lat_cnt    <= '0;
            r_last_grant <= PORT_CPU;
            r_grant_port <= PORT_UART;
            r_sram_en    <= 1'b0;
            r_sram_rw    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_data  <= '0;
            r_uart_done  <= 1'b0;
            r_cpu_done   <= 1'b0;
            r_uart_data  <= '0;
            r_cpu_data   <= '0;
        end else begin
            r_uart_done <= w_clr_u;
            r_cpu_done  <= w_clr_c;
            if (w_grant) begin
                r_grant_port <= w_grant_port;
                r_sram_en    <= 1'b1;
                r_sram_rw    <= (w_grant_port == PORT_UART) ? w_rw_u   : w_rw_c;
                r_sram_addr  <= (w_grant_port == PORT_UART) ? w_addr_u : w_addr_c;
                r_sram_data  <= (w_grant_port == PORT_UART) ? w_data_u : w_data_c;
                r_lat_cnt    <= '0;
                // Only contested grants move the round-robin pointer.
                if (w_tie) r_last_grant <= w_grant_port;
            end else if (w_finish) begin
                r_sram_en <= 1'b0;
                if (r_sram_rw == RW_READ) begin
                    if (r_grant_port == PORT_UART) r_uart_data <= bus.sram_dataOut;
                    else                           r_cpu_data  <= bus.sram_dataOut;
                end
            end else if (r_state == ST_ACCESS) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end
        end
    end

    assign bus.sram_enable    = r_sram_en;
    assign bus.sram_readWrite = r_sram_rw;
    assign bus.sram_address   = r_sram_addr;
    assign bus.sram_dataIn    = r_sram_data;
    assign bus.uart_done      = r_uart_done;
    assign bus.cpu_done       = r_cpu_done;
    assign bus.uart_dataOut   = r_uart_data;
    assign bus.cpu_dataOut    = r_cpu_data;
    assign bus.busy           = (r_state != ST_IDLE) | w_pend_u | w_pend_c;

`ifdef MEM_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] r_uart_cnt, r_cpu_cnt, r_conf_cnt;

    // Saturating statistics; clear has priority over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_uart_cnt <= '0;
            r_cpu_cnt  <= '0;
            r_conf_cnt <= '0;
        end else if (stats_clear) begin
            r_uart_cnt <= '0;
            r_cpu_cnt  <= '0;
            r_conf_cnt <= '0;
        end else begin
            if (w_clr_u && (r_uart_cnt != '1)) r_uart_cnt <= r_uart_cnt + CNT_WIDTH'(1);
            if (w_clr_c && (r_cpu_cnt  != '1)) r_cpu_cnt  <= r_cpu_cnt  + CNT_WIDTH'(1);
            if (w_tie   && (r_conf_cnt != '1)) r_conf_cnt <= r_conf_cnt + CNT_WIDTH'(1);
        end
    end

    assign uart_grant_count = r_uart_cnt;
    assign cpu_grant_count  = r_cpu_cnt;
    assign conflict_count   = r_conf_cnt;
`else
    // Statistics disabled: counter width has no effect.
    if (CNT_WIDTH == 0) begin : g_cnt_width_unused
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: SRAM model, scoreboard per port, protocol monitor.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 32;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef MEM_ARB_STATS_EN
    logic          stats_clear;
    logic [15:0]   uart_grant_count, cpu_grant_count, conflict_count;
`endif

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1), .CNT_WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .stats_clear(stats_clear),
        .uart_grant_count(uart_grant_count),
        .cpu_grant_count(cpu_grant_count),
        .conflict_count(conflict_count)
`endif
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    exp_t uq[$];
    exp_t cq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Synchronous SRAM: read data valid one edge after the sampling edge
    task automatic sram_model();
        forever begin
            @(posedge clk);
            if (bus.sram_enable) begin
                if (bus.sram_readWrite == RW_WRITE) mem[bus.sram_address] <= bus.sram_dataIn;
                else                                bus.sram_dataOut <= mem[bus.sram_address];
            end
        end
    endtask

    // Scoreboard pop on done, plus SRAM-side stability and enable-width monitor
    task automatic monitor();
        exp_t                       e;
        int                         run = 0;
        logic [1+AW+DW-1:0]         prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else begin
                if (bus.uart_done) begin
                    n_checks++;
                    if (uq.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_uart: unexpected done, data %h", bus.uart_dataOut);
                    end else begin
                        e = uq.pop_front();
                        if (e.rw == RW_READ && bus.uart_dataOut !== e.data) begin
                            n_fail++;
                            $display("FAIL sb_uart_read: got %h expected %h", bus.uart_dataOut, e.data);
                        end else if (e.rw == RW_WRITE && mem[e.addr] !== e.data) begin
                            n_fail++;
                            $display("FAIL sb_uart_write: mem %h expected %h", mem[e.addr], e.data);
                        end
                    end
                end
                if (bus.cpu_done) begin
                    n_checks++;
                    if (cq.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_cpu: unexpected done, data %h", bus.cpu_dataOut);
                    end else begin
                        e = cq.pop_front();
                        if (e.rw == RW_READ && bus.cpu_dataOut !== e.data) begin
                            n_fail++;
                            $display("FAIL sb_cpu_read: got %h expected %h", bus.cpu_dataOut, e.data);
                        end else if (e.rw == RW_WRITE && mem[e.addr] !== e.data) begin
                            n_fail++;
                            $display("FAIL sb_cpu_write: mem %h expected %h", mem[e.addr], e.data);
                        end
                    end
                end
                if (bus.sram_enable) begin
                    if (run > 0) begin
                        n_checks++;
                        if ({bus.sram_readWrite, bus.sram_address, bus.sram_dataIn} !== prev) begin
                            n_fail++;
                            $display("FAIL sram_stable: got %h expected %h",
                                     {bus.sram_readWrite, bus.sram_address, bus.sram_dataIn}, prev);
                        end
                    end
                    prev = {bus.sram_readWrite, bus.sram_address, bus.sram_dataIn};
                    run++;
                end else begin
                    if (run > 0) begin
                        n_checks++;
                        if (run != 2) begin
                            n_fail++;
                            $display("FAIL sram_en_width: got %0d cycles expected 2", run);
                        end
                    end
                    run = 0;
                end
            end
        end
    endtask

    task automatic idle_inputs();
        bus.uart_enable = 1'b0; bus.uart_readWrite = 1'b0; bus.uart_address = '0; bus.uart_dataIn = '0;
        bus.cpu_enable  = 1'b0; bus.cpu_readWrite  = 1'b0; bus.cpu_address  = '0; bus.cpu_dataIn  = '0;
`ifdef MEM_ARB_STATS_EN
        stats_clear = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        uq.delete();
        cq.delete();
        @(negedge clk);
    endtask

    // Raise a port's enable with a request and record its expected outcome
    task automatic issue(input bit cpu, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.rw = rw; e.addr = a; e.data = (rw == RW_WRITE) ? d : mem[a];
        if (cpu) begin
            bus.cpu_enable = 1'b1; bus.cpu_readWrite = rw; bus.cpu_address = a; bus.cpu_dataIn = d;
            cq.push_back(e);
        end else begin
            bus.uart_enable = 1'b1; bus.uart_readWrite = rw; bus.uart_address = a; bus.uart_dataIn = d;
            uq.push_back(e);
        end
    endtask

    // Cycle index (1-based negedge after call) of first done per port, -1 if none
    task automatic wait_dones(input int max_cyc, output int u_at, output int c_at);
        u_at = -1; c_at = -1;
        for (int n = 1; n <= max_cyc; n++) begin
            @(negedge clk);
            if (bus.uart_done && u_at < 0) u_at = n;
            if (bus.cpu_done  && c_at < 0) c_at = n;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.sram_enable, bus.sram_readWrite, bus.sram_address, bus.sram_dataIn} !== '0) begin
            n_fail++;
            $display("FAIL reset_sram: got %h expected 0",
                     {bus.sram_enable, bus.sram_readWrite, bus.sram_address, bus.sram_dataIn});
        end
        n_checks++;
        if ({bus.uart_done, bus.cpu_done, bus.uart_dataOut, bus.cpu_dataOut} !== '0) begin
            n_fail++;
            $display("FAIL reset_ports: got %h expected 0",
                     {bus.uart_done, bus.cpu_done, bus.uart_dataOut, bus.cpu_dataOut});
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_uart_read();
        mem[15'h0010] = 32'hDEADBEEF;
        @(negedge clk);
        issue(1'b0, RW_READ, 15'h0010, '0);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            n_checks++;
            if (bus.sram_enable !== (n == 2 || n == 3)) begin
                n_fail++;
                $display("FAIL uart_read_en c%0d: got %b expected %b", n, bus.sram_enable, (n == 2 || n == 3));
            end
            n_checks++;
            if (bus.uart_done !== (n == 4)) begin
                n_fail++;
                $display("FAIL uart_read_done c%0d: got %b expected %b", n, bus.uart_done, (n == 4));
            end
            if (n == 2) begin
                n_checks++;
                if (bus.sram_address !== 15'h0010 || bus.sram_readWrite !== RW_READ) begin
                    n_fail++;
                    $display("FAIL uart_read_addr: got %h/%b expected 0010/0", bus.sram_address, bus.sram_readWrite);
                end
                // Requester changes mid-access must not disturb the buffered request
                bus.uart_address = 15'h1234;
                bus.uart_enable  = 1'b0;
            end
            if (n == 4) begin
                n_checks++;
                if (bus.uart_dataOut !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL uart_read_data: got %h expected deadbeef", bus.uart_dataOut);
                end
            end
        end
    endtask

    task automatic test_cpu_write();
        logic [DW-1:0] old_out;
        old_out = bus.cpu_dataOut;
        @(negedge clk);
        issue(1'b1, RW_WRITE, 15'h7FFF, 32'h12345678);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 2 || n == 3) begin
                n_checks++;
                if ({bus.sram_enable, bus.sram_readWrite, bus.sram_address, bus.sram_dataIn} !==
                    {1'b1, 1'b1, 15'h7FFF, 32'h12345678}) begin
                    n_fail++;
                    $display("FAIL cpu_write_bus c%0d: got %b/%b/%h/%h expected 1/1/7fff/12345678", n,
                             bus.sram_enable, bus.sram_readWrite, bus.sram_address, bus.sram_dataIn);
                end
            end
            n_checks++;
            if (bus.cpu_done !== (n == 4)) begin
                n_fail++;
                $display("FAIL cpu_write_done c%0d: got %b expected %b", n, bus.cpu_done, (n == 4));
            end
            if (n == 1) bus.cpu_enable = 1'b0;
        end
        n_checks++;
        if (bus.cpu_dataOut !== old_out) begin
            n_fail++;
            $display("FAIL cpu_write_dataout: got %h expected %h", bus.cpu_dataOut, old_out);
        end
    endtask

    task automatic test_tie();
        int u_at, c_at;
        do_reset();
        issue(1'b0, RW_READ, 15'h0020, '0);
        issue(1'b1, RW_READ, 15'h4020, '0);
        wait_dones(10, u_at, c_at);
        n_checks++;
        if (u_at != 4 || c_at != 7) begin
            n_fail++;
            $display("FAIL tie_first: got uart@%0d cpu@%0d expected uart@4 cpu@7", u_at, c_at);
        end
        bus.uart_enable = 1'b0; bus.cpu_enable = 1'b0;
        repeat (2) @(negedge clk);
        issue(1'b0, RW_READ, 15'h0021, '0);
        issue(1'b1, RW_READ, 15'h4021, '0);
        wait_dones(10, u_at, c_at);
        n_checks++;
        if (c_at != 4 || u_at != 7) begin
            n_fail++;
            $display("FAIL tie_second: got uart@%0d cpu@%0d expected cpu@4 uart@7", u_at, c_at);
        end
        bus.uart_enable = 1'b0; bus.cpu_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int u_at, c_at;
        issue(1'b1, RW_READ, 15'h0055, '0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.sram_enable !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got en %b busy %b expected 0 0", bus.sram_enable, bus.busy);
        end
        cq.delete();
        bus.cpu_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_dones(6, u_at, c_at);
        n_checks++;
        if (u_at != -1 || c_at != -1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got uart@%0d cpu@%0d busy %b expected none none 0", u_at, c_at, bus.busy);
        end
    endtask

    task automatic test_hold();
        int cnt = 0;
        issue(1'b0, RW_READ, 15'h0100, '0);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.uart_done) cnt++;
        end
        n_checks++;
        if (cnt != 1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_single: got %0d dones busy %b expected 1 0", cnt, bus.busy);
        end
        bus.uart_enable = 1'b0;
        @(negedge clk);
        issue(1'b0, RW_READ, 15'h0101, '0);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.uart_done) cnt++;
        end
        n_checks++;
        if (cnt != 2) begin
            n_fail++;
            $display("FAIL hold_second: got %0d dones expected 2", cnt);
        end
        bus.uart_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int            u_at, c_at;
        logic          rw_u, rw_c;
        logic [AW-1:0] a_u, a_c;
        for (int k = 0; k < 8; k++) begin
            rw_u = 1'($urandom_range(0, 1));
            rw_c = 1'($urandom_range(0, 1));
            a_u  = AW'($urandom_range(32'h0000, 32'h3FFF));
            a_c  = AW'($urandom_range(32'h4000, 32'h7FFF));
            issue(1'b0, rw_u, a_u, $urandom);
            if (k % 2 == 1) @(negedge clk);
            issue(1'b1, rw_c, a_c, $urandom);
            wait_dones(12, u_at, c_at);
            n_checks++;
            if (u_at < 1 || u_at > 8 || c_at < 1 || c_at > 8) begin
                n_fail++;
                $display("FAIL b2b_latency r%0d: got uart@%0d cpu@%0d expected both within 8", k, u_at, c_at);
            end
            bus.uart_enable = 1'b0; bus.cpu_enable = 1'b0;
            @(negedge clk);
        end
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        int u_at, c_at;
        do_reset();
        issue(1'b0, RW_READ, 15'h0200, '0);
        issue(1'b1, RW_READ, 15'h4200, '0);
        wait_dones(10, u_at, c_at);
        bus.uart_enable = 1'b0; bus.cpu_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            issue(k == 2, RW_READ, AW'(32'h0300 + k), '0);
            wait_dones(6, u_at, c_at);
            bus.uart_enable = 1'b0; bus.cpu_enable = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (uart_grant_count !== 16'd3 || cpu_grant_count !== 16'd2 || conflict_count !== 16'd1) begin
            n_fail++;
            $display("FAIL stats_counts: got %0d/%0d/%0d expected 3/2/1",
                     uart_grant_count, cpu_grant_count, conflict_count);
        end
        stats_clear = 1'b1;
        @(negedge clk);
        stats_clear = 1'b0;
        n_checks++;
        if ({uart_grant_count, cpu_grant_count, conflict_count} !== '0) begin
            n_fail++;
            $display("FAIL stats_clear: got %0d/%0d/%0d expected 0/0/0",
                     uart_grant_count, cpu_grant_count, conflict_count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        bus.sram_dataOut = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA5A50000 ^ DW'(i * 7);
        fork
            sram_model();
            monitor();
        join_none
        test_reset();
        test_uart_read();
        test_cpu_write();
        test_tie();
        test_reset_mid();
        test_hold();
        test_back_to_back();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if (uq.size() != 0 || cq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d/%0d outstanding expected 0/0", uq.size(), cq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
